slave_readout_mc: RTL and testbench
===================================

// Module: slave_readout_mc
// PURPOSE
//  Multi-channel read-out slave: CHANNELS independent message buffers, each filled by an
//  internal deterministic generator on new_msg, read back by the master through a
//  pipelined request port with a per-channel 2-word access-counter header.
//  Sits between the on-chip test-pattern source and the host read bus.
// PARAMETERS
//  DATA_WIDTH  8   width of one data word / one header word
//  ADDR_WIDTH  8   buffer address width; DEPTH = 2**ADDR_WIDTH words per channel
//  CHANNELS    2   number of buffers (>=2); CH_W = $clog2(CHANNELS)
// PORTS
//  clk        in   1            single clock, all logic on posedge
//  rst_l      in   1            asynchronous, active-low reset
//  new_msg    in   CHANNELS     per-channel pulse: start refill of that buffer
//  ready      out  CHANNELS     buffer c holds a complete message
//  msg_drop   out  CHANNELS     1-cycle pulse: new_msg[c] ignored (fill in progress)
//  rd_rq      in   1            read request, one per cycle max
//  rd_ch      in   CH_W         channel of the request
//  rd_addr    in   16           word address within channel
//  data_o     out  DATA_WIDTH   read data
//  rd_valid   out  1            data_o/rd_err valid this cycle
//  rd_err     out  1            request was out of range or channel not ready
//  data_par   out  1            even parity of data_o (SLAVE_RD_PARITY_EN only)
// BEHAVIOUR
//  Reset: ready=0, msg_drop=0, data_o=0, rd_valid=0, rd_err=0, data_par=0; all FSMs IDLE,
//   fill counters and header counters 0. Buffer RAM not cleared. Reset mid-fill aborts fill.
//  Fill FSM per channel: IDLE -> FILL -> RDY.
//   IDLE/RDY + new_msg[c]: go FILL, widx=0, msg_n[c]+=1 (DATA_WIDTH bits, wraps), ready[c]=0
//    from next cycle.
//   FILL: one write/cycle, RAM_c[widx] = (widx + msg_n[c] + c) mod 2**DATA_WIDTH;
//    after widx=DEPTH-1 -> RDY, ready[c]=1 next cycle. Fill takes exactly DEPTH cycles.
//   new_msg[c] while FILL: ignored, msg_drop[c]=1 for one cycle.
//   Channels fill independently and concurrently.
//  Read pipeline, fixed latency 2: request sampled at cycle T, result at T+2
//   (rd_valid=1 for one cycle); back-to-back requests every cycle sustained.
//   rd_addr 0: high word of hdr[rd_ch]; rd_addr 1: low word of hdr[rd_ch].
//   rd_addr 2..DEPTH+1: RAM_ch[rd_addr-2].
//   rd_addr > DEPTH+1 or rd_ch >= CHANNELS: rd_err=1, data_o=0.
//   RAM read while channel not RDY: rd_err=1, data_o=0; header reads never err.
//  Header: hdr[c] is 2*DATA_WIDTH bits, +1 on each accepted read of rd_addr 0 on channel
//   c; the returned value is the pre-increment value. Wraps all-ones -> 0. Addr 1
//   returns the low word of the current value (no increment).
//  Same-cycle write and read of one RAM location: read returns old data.
//  When rd_valid=0, data_o holds its last value.
// CONFIGURATION
//  SLAVE_RD_PARITY_EN defined: data_par port present, registered with data_o
//   (^data_o at T+2); forced 0 with rd_err.
//  Not defined: data_par port and parity logic absent; all other behaviour identical.
// TESTING
//  Reset, new_msg[0] pulse -> ready[0]=1 exactly DEPTH+1 cycles after the pulse;
//   ready[1] stays 0.
//  After first fill of ch1 (msg_n=1), read ch1 addr 2,3,DEPTH+1 back-to-back ->
//   data 2,3,(DEPTH+1) mod 256 at T+2,T+3,T+4, rd_err=0.
//  Read ch0 addr 0 three times, then addr 1 -> high words 0,0,0; low word 3;
//   preset hdr=16'hFFFF -> addr 0 returns FF, next addr 1 returns 00.
//  new_msg[0] mid-fill -> msg_drop[0] pulse, fill length unchanged; read ch0 addr 5
//   during fill -> rd_err=1, data_o=0.
//  Read addr DEPTH+2 or rd_ch=CHANNELS -> rd_err=1; assert rst_l mid-fill -> all outputs
//   0 immediately, ready=0.
//  Parity build: data 8'h07 -> data_par=1; 8'h03 -> data_par=0.

Source files
------------

// File: rtl/slave_readout_mc_if.sv
// slave_readout_mc_if: message-control and pipelined read bus of slave_readout_mc.
// data_par exists only when SLAVE_RD_PARITY_EN is defined.
interface slave_readout_mc_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS = 2
);
  localparam int CH_W = $clog2(CHANNELS);
  logic [CHANNELS-1:0] new_msg;
  logic [CHANNELS-1:0] ready;
  logic [CHANNELS-1:0] msg_drop;
  logic rd_rq;
  logic [CH_W-1:0] rd_ch;
  logic [15:0] rd_addr;
  logic [DATA_WIDTH-1:0] data_o;
  logic rd_valid;
  logic rd_err;
`ifdef SLAVE_RD_PARITY_EN
  logic data_par;
  modport master (
    output new_msg, rd_rq, rd_ch, rd_addr,
    input ready, msg_drop, data_o, rd_valid, rd_err, data_par
  );
  modport slave (
    input new_msg, rd_rq, rd_ch, rd_addr,
    output ready, msg_drop, data_o, rd_valid, rd_err, data_par
  );
`else
  modport master (
    output new_msg, rd_rq, rd_ch, rd_addr,
    input ready, msg_drop, data_o, rd_valid, rd_err
  );
  modport slave (
    input new_msg, rd_rq, rd_ch, rd_addr,
    output ready, msg_drop, data_o, rd_valid, rd_err
  );
`endif
endinterface

// File: rtl/slave_readout_mc.sv
// slave_readout_mc: per-channel generated message buffers read back through a 2-stage pipeline
// with a 2-word access header; SLAVE_RD_PARITY_EN adds the registered even-parity output data_par.
module slave_readout_mc #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int CHANNELS = 2
) (
  input logic clk,
  input logic rst_l,
  slave_readout_mc_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CH_W = $clog2(CHANNELS);
  localparam int HW = 2 * DATA_WIDTH;
  typedef enum logic [1:0] {IDLE, FILL, RDY} state_t;
  state_t state [CHANNELS];
  state_t state_nx [CHANNELS];
  logic [ADDR_WIDTH-1:0] widx [CHANNELS];
  logic [DATA_WIDTH-1:0] msg_n [CHANNELS];
  logic [HW-1:0] hdr [CHANNELS];
  logic [DATA_WIDTH-1:0] ram [CHANNELS][DEPTH];
  logic [CHANNELS-1:0] start, filling, rdy, drop;
  logic ch_ok, addr_hdr, addr_ok, err, hdr_inc;
  logic [CH_W-1:0] ch;
  logic [ADDR_WIDTH-1:0] ridx;
  logic s1_valid, s1_err, s1_ram, valid_q, err_q;
  logic [DATA_WIDTH-1:0] s1_word, ram_q, dnx, data_q;

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      filling[c] = state[c] == FILL;
      rdy[c] = state[c] == RDY;
      start[c] = bus.new_msg[c] && !filling[c];
      state_nx[c] = start[c] ? FILL : (filling[c] && widx[c] == '1) ? RDY : state[c];
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int c = 0; c < CHANNELS; c++) begin
        state[c] <= IDLE;
        widx[c] <= '0;
        msg_n[c] <= '0;
      end
      drop <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        state[c] <= state_nx[c];
        widx[c] <= start[c] ? '0 : widx[c] + ADDR_WIDTH'(filling[c]);
        msg_n[c] <= msg_n[c] + DATA_WIDTH'(start[c]);
      end
      drop <= bus.new_msg & filling;
    end
  end

  // Read and write share one block so a same-cycle collision returns the old word.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++)
      if (filling[c]) ram[c][widx[c]] <= DATA_WIDTH'(widx[c]) + msg_n[c] + DATA_WIDTH'(c);
    ram_q <= ram[ch][ridx];
  end

  always_comb begin
    ch_ok = int'(bus.rd_ch) < CHANNELS;
    ch = ch_ok ? bus.rd_ch : '0;
    addr_hdr = bus.rd_addr < 16'd2;
    addr_ok = int'(bus.rd_addr) <= DEPTH + 1;
    ridx = ADDR_WIDTH'(bus.rd_addr - 16'd2);
    err = !ch_ok || !addr_ok || (!addr_hdr && !rdy[ch]);
    hdr_inc = bus.rd_rq && ch_ok && bus.rd_addr == 16'd0;
    dnx = s1_err ? '0 : s1_ram ? ram_q : s1_word;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int c = 0; c < CHANNELS; c++) hdr[c] <= '0;
      s1_valid <= 1'b0;
      s1_err <= 1'b0;
      s1_ram <= 1'b0;
      s1_word <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      data_q <= '0;
    end else begin
      if (hdr_inc) hdr[ch] <= hdr[ch] + HW'(1);
      s1_valid <= bus.rd_rq;
      s1_err <= err;
      s1_ram <= !addr_hdr;
      s1_word <= bus.rd_addr[0] ? hdr[ch][DATA_WIDTH-1:0] : hdr[ch][HW-1:DATA_WIDTH];
      valid_q <= s1_valid;
      err_q <= s1_valid && s1_err;
      if (s1_valid) data_q <= dnx;
    end
  end

`ifdef SLAVE_RD_PARITY_EN
  logic par_q;
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) par_q <= 1'b0;
    else if (s1_valid) par_q <= ^dnx;
  end
  assign bus.data_par = par_q;
`endif

  assign bus.ready = rdy;
  assign bus.msg_drop = drop;
  assign bus.data_o = data_q;
  assign bus.rd_valid = valid_q;
  assign bus.rd_err = err_q;
endmodule

// File: tb/tb_slave_readout_mc.sv
// tb_slave_readout_mc: directed and random checks of slave_readout_mc against a
// transaction-level model (fill timing from pulse cycle, buffer contents by formula, header counts).
module tb_slave_readout_mc;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int NCH = 3;
  localparam int DEPTH = 2 ** AW;
  typedef struct { bit v; bit e; int d; } res_t;
  logic clk = 1'b0;
  logic rst_l = 1'b0;
  int total = 0;
  int bad = 0;
  int edge_n = 0;
  int m_start [NCH];
  int m_msg [NCH];
  int m_hdr [NCH];
  res_t pipe [$];
  logic [NCH-1:0] exp_ready, exp_drop;
  logic exp_valid, exp_err;
  logic [DW-1:0] exp_data;

  slave_readout_mc_if #(.DATA_WIDTH(DW), .CHANNELS(NCH)) bus ();
  slave_readout_mc #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CHANNELS(NCH)) dut (
    .clk(clk), .rst_l(rst_l), .bus(bus));

  always #5 clk = ~clk;

  function automatic bit m_ready(int c, int e);
    return m_start[c] >= 0 && e > m_start[c] + DEPTH;
  endfunction

  function automatic bit m_filling(int c, int e);
    return m_start[c] >= 0 && e <= m_start[c] + DEPTH;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_start[c] = -1;
      m_msg[c] = 0;
      m_hdr[c] = 0;
    end
    pipe.delete();
    exp_ready = '0;
    exp_drop = '0;
    exp_valid = 1'b0;
    exp_err = 1'b0;
    exp_data = '0;
  endtask

  // One clock: drive inputs, advance the model on the sampling edge, settle 1 time unit.
  task automatic tick(input logic [NCH-1:0] nm, input logic rq, input logic [1:0] ch, input int addr);
    res_t r, o;
    bus.new_msg = nm;
    bus.rd_rq = rq;
    bus.rd_ch = ch;
    bus.rd_addr = 16'(addr);
    @(posedge clk);
    edge_n++;
    r.v = rq; r.e = 1'b0; r.d = 0;
    if (rq) begin
      if (int'(ch) >= NCH || addr > DEPTH + 1) r.e = 1'b1;
      else if (addr == 0) begin
        r.d = m_hdr[ch] / 256;
        m_hdr[ch] = (m_hdr[ch] + 1) % 65536;
      end
      else if (addr == 1) r.d = m_hdr[ch] % 256;
      else if (!m_ready(int'(ch), edge_n)) r.e = 1'b1;
      else r.d = (addr - 2 + m_msg[ch] + int'(ch)) % 256;
    end
    pipe.push_back(r);
    for (int c = 0; c < NCH; c++) begin
      exp_drop[c] = 1'b0;
      if (nm[c]) begin
        if (m_filling(c, edge_n)) exp_drop[c] = 1'b1;
        else begin
          m_msg[c] = (m_msg[c] + 1) % 256;
          m_start[c] = edge_n;
        end
      end
      exp_ready[c] = m_ready(c, edge_n + 1);
    end
    exp_valid = 1'b0;
    exp_err = 1'b0;
    if (pipe.size() > 1) begin
      o = pipe.pop_front();
      exp_valid = o.v;
      exp_err = o.v && o.e;
      if (o.v) exp_data = 8'(o.d);
    end
    #1;
  endtask

  task automatic test_reset();
    bus.new_msg = '0; bus.rd_rq = 1'b0; bus.rd_ch = '0; bus.rd_addr = '0;
    rst_l = 1'b0;
    #2;
    total++; if (bus.ready !== 3'b000) begin bad++; $display("FAIL reset_ready got=%b exp=000", bus.ready); end
    total++; if (bus.msg_drop !== 3'b000) begin bad++; $display("FAIL reset_drop got=%b exp=000", bus.msg_drop); end
    total++; if (bus.data_o !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", bus.data_o); end
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.rd_valid); end
    total++; if (bus.rd_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.rd_err); end
`ifdef SLAVE_RD_PARITY_EN
    total++; if (bus.data_par !== 1'b0) begin bad++; $display("FAIL reset_par got=%b exp=0", bus.data_par); end
`endif
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    rst_l = 1'b1;
  endtask

  task automatic test_fill();
    int n;
    bit r1;
    n = 1;
    r1 = 1'b0;
    tick(3'b001, 1'b0, 2'd0, 0);
    while (!bus.ready[0] && n < DEPTH + 16) begin
      r1 |= bus.ready[1];
      tick('0, 1'b0, 2'd0, 0);
      n++;
    end
    total++; if (n != DEPTH + 1) begin bad++; $display("FAIL fill_latency got=%0d exp=%0d", n, DEPTH + 1); end
    total++; if (r1 || bus.ready[1] !== 1'b0) begin bad++; $display("FAIL fill_ready1 got=%b exp=0", r1 | bus.ready[1]); end
    total++; if (bus.ready !== exp_ready) begin bad++; $display("FAIL fill_ready got=%b exp=%b", bus.ready, exp_ready); end
  endtask

  task automatic test_readback();
    tick(3'b010, 1'b0, 2'd0, 0);
    repeat (DEPTH) tick('0, 1'b0, 2'd0, 0);
    total++; if (bus.ready[1] !== 1'b1) begin bad++; $display("FAIL rb_ready got=%b exp=1", bus.ready[1]); end
    tick('0, 1'b1, 2'd1, 2);
    tick('0, 1'b1, 2'd1, 3);
    total++; if (bus.rd_valid !== 1'b1 || bus.rd_err !== 1'b0 || bus.data_o !== 8'(2))
      begin bad++; $display("FAIL rb_a2 got=%b/%b/%h exp=1/0/02", bus.rd_valid, bus.rd_err, bus.data_o); end
    tick('0, 1'b1, 2'd1, DEPTH + 1);
    total++; if (bus.rd_valid !== 1'b1 || bus.rd_err !== 1'b0 || bus.data_o !== 8'(3))
      begin bad++; $display("FAIL rb_a3 got=%b/%b/%h exp=1/0/03", bus.rd_valid, bus.rd_err, bus.data_o); end
    tick('0, 1'b0, 2'd0, 0);
    total++; if (bus.rd_valid !== 1'b1 || bus.rd_err !== 1'b0 || bus.data_o !== 8'((DEPTH + 1) % 256))
      begin bad++; $display("FAIL rb_last got=%b/%b/%h exp=1/0/%h", bus.rd_valid, bus.rd_err, bus.data_o, 8'((DEPTH + 1) % 256)); end
    tick('0, 1'b0, 2'd0, 0);
    total++; if (bus.rd_valid !== 1'b0 || bus.data_o !== 8'((DEPTH + 1) % 256))
      begin bad++; $display("FAIL rb_hold got=%b/%h exp=0/%h", bus.rd_valid, bus.data_o, 8'((DEPTH + 1) % 256)); end
  endtask

  task automatic test_header();
    tick('0, 1'b1, 2'd0, 0);
    tick('0, 1'b1, 2'd0, 0);
    total++; if (bus.rd_valid !== 1'b1 || bus.data_o !== 8'h00) begin bad++; $display("FAIL hdr_hi0 got=%b/%h exp=1/00", bus.rd_valid, bus.data_o); end
    tick('0, 1'b1, 2'd0, 0);
    total++; if (bus.rd_valid !== 1'b1 || bus.data_o !== 8'h00) begin bad++; $display("FAIL hdr_hi1 got=%b/%h exp=1/00", bus.rd_valid, bus.data_o); end
    tick('0, 1'b1, 2'd0, 1);
    total++; if (bus.rd_valid !== 1'b1 || bus.data_o !== 8'h00) begin bad++; $display("FAIL hdr_hi2 got=%b/%h exp=1/00", bus.rd_valid, bus.data_o); end
    tick('0, 1'b0, 2'd0, 0);
    total++; if (bus.rd_valid !== 1'b1 || bus.data_o !== 8'h03) begin bad++; $display("FAIL hdr_lo got=%b/%h exp=1/03", bus.rd_valid, bus.data_o); end
    for (int i = 0; i < 65532; i++) tick('0, 1'b1, 2'd0, 0);
    tick('0, 1'b1, 2'd0, 0);
    tick('0, 1'b1, 2'd0, 1);
    total++; if (bus.data_o !== 8'hFF || bus.rd_err !== 1'b0) begin bad++; $display("FAIL hdr_wrap_hi got=%h/%b exp=ff/0", bus.data_o, bus.rd_err); end
    tick('0, 1'b0, 2'd0, 0);
    tick('0, 1'b0, 2'd0, 0);
    total++; if (bus.data_o !== 8'h00 || bus.data_o !== exp_data) begin bad++; $display("FAIL hdr_wrap_lo got=%h exp=00", bus.data_o); end
  endtask

  task automatic test_drop();
    int n;
    tick('0, 1'b1, 2'd1, 9);
    tick('0, 1'b0, 2'd0, 0);
    total++; if (bus.data_o !== 8'h09) begin bad++; $display("FAIL drop_pre got=%h exp=09", bus.data_o); end
    tick(3'b001, 1'b0, 2'd0, 0);
    n = 1;
    repeat (9) begin tick('0, 1'b0, 2'd0, 0); n++; end
    tick(3'b001, 1'b0, 2'd0, 0); n++;
    total++; if (bus.msg_drop !== 3'b001) begin bad++; $display("FAIL drop_pulse got=%b exp=001", bus.msg_drop); end
    tick('0, 1'b1, 2'd0, 5); n++;
    total++; if (bus.msg_drop !== 3'b000) begin bad++; $display("FAIL drop_clear got=%b exp=000", bus.msg_drop); end
    tick('0, 1'b0, 2'd0, 0); n++;
    total++; if (bus.rd_valid !== 1'b1 || bus.rd_err !== 1'b1 || bus.data_o !== 8'h00)
      begin bad++; $display("FAIL drop_rd_busy got=%b/%b/%h exp=1/1/00", bus.rd_valid, bus.rd_err, bus.data_o); end
    while (!bus.ready[0] && n < DEPTH + 16) begin tick('0, 1'b0, 2'd0, 0); n++; end
    total++; if (n != DEPTH + 1) begin bad++; $display("FAIL drop_fill_len got=%0d exp=%0d", n, DEPTH + 1); end
  endtask

  task automatic test_range();
    tick('0, 1'b1, 2'd1, DEPTH + 1);
    tick('0, 1'b1, 2'd1, DEPTH + 2);
    total++; if (bus.rd_err !== 1'b0 || bus.data_o !== 8'h01) begin bad++; $display("FAIL rng_edge got=%b/%h exp=0/01", bus.rd_err, bus.data_o); end
    tick('0, 1'b1, 2'd3, 2);
    total++; if (bus.rd_valid !== 1'b1 || bus.rd_err !== 1'b1 || bus.data_o !== 8'h00)
      begin bad++; $display("FAIL rng_addr got=%b/%b/%h exp=1/1/00", bus.rd_valid, bus.rd_err, bus.data_o); end
    tick('0, 1'b0, 2'd0, 0);
    total++; if (bus.rd_valid !== 1'b1 || bus.rd_err !== 1'b1 || bus.data_o !== 8'h00)
      begin bad++; $display("FAIL rng_ch got=%b/%b/%h exp=1/1/00", bus.rd_valid, bus.rd_err, bus.data_o); end
    tick('0, 1'b0, 2'd0, 0);
    total++; if (bus.rd_valid !== 1'b0 || bus.rd_err !== 1'b0) begin bad++; $display("FAIL rng_idle got=%b/%b exp=0/0", bus.rd_valid, bus.rd_err); end
  endtask

`ifdef SLAVE_RD_PARITY_EN
  task automatic test_parity();
    tick('0, 1'b1, 2'd1, 7);
    tick('0, 1'b1, 2'd1, 3);
    total++; if (bus.data_o !== 8'h07 || bus.data_par !== 1'b1) begin bad++; $display("FAIL par_07 got=%h/%b exp=07/1", bus.data_o, bus.data_par); end
    tick('0, 1'b0, 2'd0, 0);
    total++; if (bus.data_o !== 8'h03 || bus.data_par !== 1'b0) begin bad++; $display("FAIL par_03 got=%h/%b exp=03/0", bus.data_o, bus.data_par); end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      logic [NCH-1:0] nm;
      int sel, addr;
      for (int c = 0; c < NCH; c++) nm[c] = $urandom_range(0, 199) == 0;
      sel = int'($urandom_range(0, 15));
      addr = sel < 2 ? 0 : sel < 4 ? 1 : sel == 4 ? DEPTH + 2 + int'($urandom_range(0, 3)) :
             sel == 5 ? int'($urandom_range(DEPTH + 2, 65535)) : int'($urandom_range(2, DEPTH + 1));
      tick(nm, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), addr);
      total++; if (bus.ready !== exp_ready) begin bad++; $display("FAIL rnd_ready i=%0d got=%b exp=%b", i, bus.ready, exp_ready); end
      total++; if (bus.msg_drop !== exp_drop) begin bad++; $display("FAIL rnd_drop i=%0d got=%b exp=%b", i, bus.msg_drop, exp_drop); end
      total++; if (bus.rd_valid !== exp_valid) begin bad++; $display("FAIL rnd_valid i=%0d got=%b exp=%b", i, bus.rd_valid, exp_valid); end
      total++; if (bus.rd_err !== exp_err) begin bad++; $display("FAIL rnd_err i=%0d got=%b exp=%b", i, bus.rd_err, exp_err); end
      total++; if (bus.data_o !== exp_data) begin bad++; $display("FAIL rnd_data i=%0d got=%h exp=%h", i, bus.data_o, exp_data); end
`ifdef SLAVE_RD_PARITY_EN
      total++; if (bus.data_par !== ^exp_data) begin bad++; $display("FAIL rnd_par i=%0d got=%b exp=%b", i, bus.data_par, ^exp_data); end
`endif
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    tick(3'b100, 1'b0, 2'd0, 0);
    repeat (20) tick('0, 1'b0, 2'd0, 0);
    tick('0, 1'b1, 2'd3, 0);
    tick('0, 1'b0, 2'd0, 0);
    total++; if (bus.rd_valid !== 1'b1 || bus.rd_err !== 1'b1) begin bad++; $display("FAIL mid_pre got=%b/%b exp=1/1", bus.rd_valid, bus.rd_err); end
    #3;
    rst_l = 1'b0;
    #1;
    total++; if (bus.ready !== 3'b000) begin bad++; $display("FAIL mid_ready got=%b exp=000", bus.ready); end
    total++; if (bus.rd_valid !== 1'b0 || bus.rd_err !== 1'b0) begin bad++; $display("FAIL mid_rd got=%b/%b exp=0/0", bus.rd_valid, bus.rd_err); end
    total++; if (bus.data_o !== 8'h00 || bus.msg_drop !== 3'b000) begin bad++; $display("FAIL mid_data got=%h/%b exp=00/000", bus.data_o, bus.msg_drop); end
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    rst_l = 1'b1;
    seen = 1'b0;
    repeat (DEPTH + 8) begin
      tick('0, 1'b0, 2'd0, 0);
      if (bus.ready !== 3'b000) seen = 1'b1;
    end
    total++; if (seen) begin bad++; $display("FAIL mid_abort got=1 exp=0 (ready after aborted fill)"); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_readback();
    test_header();
    test_drop();
    test_range();
`ifdef SLAVE_RD_PARITY_EN
    test_parity();
`endif
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
